// File: rtl/mult_seq_if.sv
// Handshake and result bundle between a requester and the mult_seq multiplier.
interface mult_seq_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] higher;
  logic [CNT_W-1:0] count;

  // Requester side: issues operands, observes status and product.
  modport master (
    output start, is_signed, a, b,
    input  busy, done, lower, higher, count
  );

  // Multiplier side.
  modport slave (
    input  start, is_signed, a, b,
    output busy, done, lower, higher, count
  );
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier, one partial product per cycle, with
// sign handled by multiplying magnitudes and negating the final product.
module mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mult_seq_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic             neg;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mult;
  logic [WIDTH-1:0] acc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] higher;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0]   a_mag_c;
  logic [WIDTH-1:0]   b_mag_c;
  logic [WIDTH:0]     sum_c;
  logic [2*WIDTH-1:0] prod_c;

  // Operand magnitudes, partial-product add (carry kept) and sign fix-up.
  always_comb begin
    a_mag_c = bus.a;
    b_mag_c = bus.b;
    if (bus.is_signed && bus.a[WIDTH-1]) a_mag_c = WIDTH'(-bus.a);
    if (bus.is_signed && bus.b[WIDTH-1]) b_mag_c = WIDTH'(-bus.b);
    sum_c  = {1'b0, acc} + (mult[0] ? {1'b0, mcand} : (WIDTH+1)'(0));
    prod_c = neg ? (2*WIDTH)'(-{acc, mult}) : {acc, mult};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      neg    <= 1'b0;
      mcand  <= '0;
      mult   <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lower  <= '0;
      higher <= '0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            mcand <= a_mag_c;
            mult  <= b_mag_c;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= sum_c[WIDTH:1];
          mult <= {sum_c[0], mult[WIDTH-1:1]};
          if (count == LAST) state <= FIX;
          else               count <= count + CNT_W'(1);
        end
        FIX: begin
          {higher, lower} <= prod_c;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.lower  = lower;
  assign bus.higher = higher;
  assign bus.count  = count;
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq at WIDTH=32 and WIDTH=8.
module tb_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] q32[$];
  logic [15:0] q8[$];

  mult_seq_if #(.WIDTH(32)) if32();
  mult_seq_if #(.WIDTH(8))  if8();

  mult_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

  always #5 clk = ~clk;

  // Reference products by native multiplication.
  function automatic logic [63:0] model32(logic [31:0] a, logic [31:0] b, logic s);
    longint x, y;
    if (s) begin x = longint'($signed(a)); y = longint'($signed(b)); end
    else   begin x = longint'(a);          y = longint'(b);          end
    return 64'(x * y);
  endfunction

  function automatic logic [15:0] model8(logic [7:0] a, logic [7:0] b, logic s);
    longint x, y;
    if (s) begin x = longint'($signed(a)); y = longint'($signed(b)); end
    else   begin x = longint'(a);          y = longint'(b);          end
    return 16'(x * y);
  endfunction

  // Drivers: enqueue expected product, pulse start, then scramble operands.
  task automatic start32(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         input logic [63:0] exp);
    q32.push_back(exp);
    if32.a = av; if32.b = bv; if32.is_signed = sv; if32.start = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0;
    if32.a = $urandom; if32.b = $urandom; if32.is_signed = 1'($urandom);
  endtask

  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    q8.push_back(model8(av, bv, sv));
    if8.a = av; if8.b = bv; if8.is_signed = sv; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.is_signed = 1'($urandom);
  endtask

  // Bounded waits for done; lat = edges since call, -1 on timeout.
  task automatic wait_done32(output logic [63:0] got, output int lat);
    lat = -1; got = '0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (if32.done) begin lat = n; got = {if32.higher, if32.lower}; break; end
    end
  endtask

  task automatic wait_done8(output logic [15:0] got, output int lat);
    lat = -1; got = '0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (if8.done) begin lat = n; got = {if8.higher, if8.lower}; break; end
    end
  endtask

  task automatic test_reset();
    if32.start = 1'b0; if32.is_signed = 1'b0; if32.a = '0; if32.b = '0;
    if8.start  = 1'b0; if8.is_signed  = 1'b0; if8.a  = '0; if8.b  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({if32.busy, if32.done, if32.lower, if32.higher, if32.count} !== '0) begin
      errors++;
      $display("FAIL reset32 got busy=%0b done=%0b lo=%h hi=%h cnt=%0d want all 0",
               if32.busy, if32.done, if32.lower, if32.higher, if32.count);
    end
    checks++;
    if ({if8.busy, if8.done, if8.lower, if8.higher, if8.count} !== '0) begin
      errors++;
      $display("FAIL reset8 got busy=%0b done=%0b lo=%h hi=%h", if8.busy, if8.done, if8.lower, if8.higher);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_basic();
    logic [63:0] got, exp;
    int lat;
    start32(32'd16, 32'd3, 1'b0, 64'd48);
    checks++;
    if (if32.busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %0b want 1", if32.busy); end
    wait_done32(got, lat);
    exp = q32.pop_front();
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL latency_basic got %0d want 33", lat); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL prod_basic got %h want %h", got, exp); end
    checks++;
    if (if32.busy !== 1'b0) begin errors++; $display("FAIL busy_on_done got %0b want 0", if32.busy); end
    @(posedge clk); #1;
    checks++;
    if (if32.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %0b want 0", if32.done); end
    checks++;
    if ({if32.higher, if32.lower} !== 64'd48) begin
      errors++; $display("FAIL result_hold got %h want %h", {if32.higher, if32.lower}, 64'd48);
    end
  endtask

  task automatic test_signed_modes();
    logic [31:0] ta[8];
    logic [31:0] tb[8];
    logic        ts[8];
    logic [63:0] te[8];
    logic [63:0] got, exp;
    int lat;
    ta[0] = 32'hFFFFFFF0; tb[0] = 32'd3;        ts[0] = 1'b1; te[0] = 64'hFFFFFFFF_FFFFFFD0;
    ta[1] = 32'hFFFFFFF0; tb[1] = 32'd3;        ts[1] = 1'b0; te[1] = 64'h00000002_FFFFFFD0;
    ta[2] = 32'h80000000; tb[2] = 32'h80000000; ts[2] = 1'b1; te[2] = 64'h40000000_00000000;
    ta[3] = 32'h80000000; tb[3] = 32'h80000000; ts[3] = 1'b0; te[3] = 64'h40000000_00000000;
    ta[4] = 32'd0;        tb[4] = 32'hFFFFFFF9; ts[4] = 1'b1; te[4] = 64'd0;
    ta[5] = 32'hFFFFFFFF; tb[5] = 32'hFFFFFFFF; ts[5] = 1'b0; te[5] = 64'hFFFFFFFE_00000001;
    ta[6] = 32'h7FFFFFFF; tb[6] = 32'h80000000; ts[6] = 1'b1; te[6] = 64'hC0000000_80000000;
    ta[7] = 32'hFFFFFFFF; tb[7] = 32'hFFFFFFFF; ts[7] = 1'b1; te[7] = 64'd1;
    for (int i = 0; i < 8; i++) begin
      start32(ta[i], tb[i], ts[i], te[i]);
      wait_done32(got, lat);
      exp = q32.pop_front();
      checks++;
      if (got !== exp || lat !== 33) begin
        errors++;
        $display("FAIL prod32_case%0d got %h lat %0d want %h lat 33", i, got, lat, exp);
      end
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = $urandom; rb = $urandom; rs = 1'(i);
      start32(ra, rb, rs, model32(ra, rb, rs));
      wait_done32(got, lat);
      exp = q32.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL prod32_rand%0d got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got, exp;
    int lat;
    start32(32'h1234, 32'h10, 1'b0, 64'h12340);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (if32.count !== 5'd10) begin errors++; $display("FAIL count_mid got %0d want 10", if32.count); end
    if32.a = 32'd5; if32.b = 32'd5; if32.is_signed = 1'b0; if32.start = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0;
    wait_done32(got, lat);
    exp = q32.pop_front();
    checks++;
    if (got !== exp || lat + 11 !== 33) begin
      errors++; $display("FAIL start_while_busy got %h lat %0d want %h lat 33", got, lat + 11, exp);
    end
    start32(32'd7, 32'd9, 1'b0, 64'd63);
    checks++;
    if ({if32.higher, if32.lower} !== 64'h12340 || if32.busy !== 1'b1) begin
      errors++; $display("FAIL start_on_done got %h busy %0b want %h busy 1",
                         {if32.higher, if32.lower}, if32.busy, 64'h12340);
    end
    wait_done32(got, lat);
    exp = q32.pop_front();
    checks++;
    if (got !== exp || lat !== 33) begin
      errors++; $display("FAIL second_op got %h lat %0d want %h lat 33", got, lat, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] got, exp;
    int lat;
    int seen;
    start32(32'd100, 32'd200, 1'b0, 64'd20000);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (if32.count !== 5'd20) begin errors++; $display("FAIL count_pre_reset got %0d want 20", if32.count); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({if32.busy, if32.done, if32.lower, if32.higher, if32.count} !== '0) begin
      errors++; $display("FAIL async_reset got busy=%0b done=%0b lo=%h hi=%h want all 0",
                         if32.busy, if32.done, if32.lower, if32.higher);
    end
    q32.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (if32.done) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL done_after_reset got %0d pulses want 0", seen); end
    start32(32'd3, 32'd4, 1'b0, 64'd12);
    wait_done32(got, lat);
    exp = q32.pop_front();
    checks++;
    if (got !== exp || lat !== 33) begin
      errors++; $display("FAIL op_after_reset got %h lat %0d want %h lat 33", got, lat, exp);
    end
  endtask

  task automatic test_w8();
    logic [7:0]  corners[6];
    logic [15:0] got, exp;
    int lat;
    corners[0] = 8'd0;   corners[1] = 8'd1;   corners[2] = 8'hFF;
    corners[3] = 8'd127; corners[4] = 8'h80;  corners[5] = 8'd255;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) begin
          start8(corners[i], corners[j], 1'(s));
          wait_done8(got, lat);
          exp = q8.pop_front();
          checks++;
          if (got !== exp || lat !== 9) begin
            errors++; $display("FAIL w8_corner s=%0d a=%h b=%h got %h lat %0d want %h lat 9",
                               s, corners[i], corners[j], got, lat, exp);
          end
        end
      end
      for (int k = 0; k < 1000; k++) begin
        start8(8'($urandom), 8'($urandom), 1'(s));
        wait_done8(got, lat);
        exp = q8.pop_front();
        checks++;
        if (got !== exp || lat !== 9) begin
          errors++; $display("FAIL w8_rand s=%0d k=%0d got %h lat %0d want %h lat 9", s, k, got, lat, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_modes();
    test_back_to_back();
    test_reset_mid_run();
    test_w8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
